// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LEN_W          = 16;
   localparam int unsigned STATE_W        = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_LEN0  = 3'd0;
   localparam state_t S_LEN1  = 3'd1;
   localparam state_t S_DATA  = 3'd2;
   localparam state_t S_WRITE = 3'd3;
   localparam state_t S_DONE  = 3'd4;
   localparam state_t S_ERR   = 3'd5;

endpackage

// File: rtl/imem_loader_byte_timeout.sv
// Idle-cycle counter between received bytes; flags expiry at TIMEOUT-1 idle cycles.
module imem_loader_byte_timeout #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expired_c
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] count;

   assign expired_c = enable && (count == CNT_W'(TIMEOUT - 1));

   // Held at zero while disabled so each enabled phase starts fresh.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (clear || !enable) begin
         count <= '0;
      end else if (!expired_c) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length-prefixed byte stream into 32-bit words
// and writes them to instruction memory while holding the CPU in reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned BYTE_CNT_W = $clog2(BYTES_PER_WORD);
   localparam int unsigned MAX_WORDS  = 1 << ADDR_W;
   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

   state_t                  state, state_nxt;
   logic [7:0]              len_hi, len_hi_nxt;
   logic [LEN_W-1:0]        len_q, len_nxt;
   logic [BYTE_CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
   logic [ADDR_W:0]         word_cnt, word_cnt_nxt;
   logic [ADDR_W-1:0]       addr_nxt;
   logic [31:0]             wdata_nxt;
   logic                    rx_ready_nxt, imem_we_nxt, cpu_hold_nxt, load_done_nxt, load_err_nxt;

   logic                    xfer_c;
   logic                    expired_c;
   logic                    timer_en_c;
   logic [LEN_W-1:0]        len_in_c;
   logic [ADDR_W:0]         word_inc_c;

   assign xfer_c     = rx_valid && rx_ready;
   assign timer_en_c = (state == S_LEN1) || (state == S_DATA);
   assign len_in_c   = {len_hi, rx_data};
   assign word_inc_c = word_cnt + 1'b1;

   imem_loader_byte_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_byte_timeout (
      .clock     (clock),
      .reset     (reset),
      .enable    (timer_en_c),
      .clear     (xfer_c),
      .expired_c (expired_c)
   );

   // Next-state, datapath and registered-output next values.
   always_comb begin
      state_nxt    = state;
      len_hi_nxt   = len_hi;
      len_nxt      = len_q;
      byte_cnt_nxt = byte_cnt;
      word_cnt_nxt = word_cnt;
      addr_nxt     = imem_addr;
      wdata_nxt    = imem_wdata;

      case (state)
         S_LEN0: begin
            if (xfer_c) begin
               len_hi_nxt = rx_data;
               state_nxt  = S_LEN1;
            end
         end
         S_LEN1: begin
            if (xfer_c) begin
               len_nxt = len_in_c;
               if (len_in_c == '0) begin
                  state_nxt = S_DONE;
               end else if (32'(len_in_c) > MAX_WORDS) begin
                  state_nxt = S_ERR;
               end else begin
                  state_nxt    = S_DATA;
                  addr_nxt     = '0;
                  byte_cnt_nxt = '0;
                  word_cnt_nxt = '0;
               end
            end else if (expired_c) begin
               state_nxt = S_ERR;
            end
         end
         S_DATA: begin
            if (xfer_c) begin
               wdata_nxt    = {imem_wdata[23:0], rx_data};
               byte_cnt_nxt = byte_cnt + 1'b1;
               if (byte_cnt == LAST_BYTE) begin
                  state_nxt = S_WRITE;
               end
            end else if (expired_c) begin
               state_nxt = S_ERR;
            end
         end
         S_WRITE: begin
            addr_nxt     = imem_addr + 1'b1;
            word_cnt_nxt = word_inc_c;
            state_nxt    = (LEN_W'(word_inc_c) == len_q) ? S_DONE : S_DATA;
         end
         S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_LEN0;
               addr_nxt  = '0;
            end
         end
         default: begin
            state_nxt = S_LEN0;
         end
      endcase

      rx_ready_nxt  = (state_nxt == S_LEN0) || (state_nxt == S_LEN1) || (state_nxt == S_DATA);
      imem_we_nxt   = (state_nxt == S_WRITE);
      cpu_hold_nxt  = (state_nxt != S_DONE);
      load_done_nxt = (state_nxt == S_DONE);
      load_err_nxt  = (state_nxt == S_ERR);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= S_LEN0;
         len_hi     <= '0;
         len_q      <= '0;
         byte_cnt   <= '0;
         word_cnt   <= '0;
         rx_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         len_hi     <= len_hi_nxt;
         len_q      <= len_nxt;
         byte_cnt   <= byte_cnt_nxt;
         word_cnt   <= word_cnt_nxt;
         rx_ready   <= rx_ready_nxt;
         imem_we    <= imem_we_nxt;
         imem_addr  <= addr_nxt;
         imem_wdata <= wdata_nxt;
         cpu_hold   <= cpu_hold_nxt;
         load_done  <= load_done_nxt;
         load_err   <= load_err_nxt;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, N=0, overflow, timeout, reset, re-arm.
module tb_imem_loader;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned TIMEOUT = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;

   int passed = 0;
   int total  = 0;
   int cycle  = 0;
   int xfer_cnt = 0;
   int we_rdy_bad = 0;

   logic [ADDR_W-1:0] wa_q[$];
   logic [31:0]       wd_q[$];
   int                wc_q[$];

   always #5 clock = ~clock;

   imem_loader #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always @(posedge clock) cycle <= cycle + 1;

   // Mid-cycle monitor: log transfers and write strobes.
   always @(negedge clock) begin
      if (rx_valid && rx_ready) xfer_cnt <= xfer_cnt + 1;
      if (imem_we) begin
         wa_q.push_back(imem_addr);
         wd_q.push_back(imem_wdata);
         wc_q.push_back(cycle);
         if (rx_ready) we_rdy_bad <= we_rdy_bad + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) check_eq("ready_wait", 32'(rx_ready), 32'd1);
      tick();
   endtask

   task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
      check_eq({tag, "_imem_we"},    32'(imem_we),    32'd0);
      check_eq({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
      check_eq({tag, "_imem_wdata"}, imem_wdata,      32'd0);
      check_eq({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
      check_eq({tag, "_load_done"},  32'(load_done),  32'd0);
      check_eq({tag, "_load_err"},   32'(load_err),   32'd0);
   endtask

   initial begin
      int base;
      int x0;
      int bb;
      int n;
      logic [7:0] v[10];

      reset    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) tick();
      check_reset_vals("por");
      reset = 1'b1;
      tick();
      check_eq("ready_after_reset", 32'(rx_ready), 32'd1);

      // N=2, back-to-back stream
      v = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
      base = wa_q.size();
      x0   = xfer_cnt;
      for (int i = 0; i < 10; i++) send_byte(v[i]);
      rx_valid = 1'b0;
      check_eq("n2_we_last", 32'(imem_we), 32'd1);
      check_eq("n2_done_early", 32'(load_done), 32'd0);
      tick();
      check_eq("n2_done", 32'(load_done), 32'd1);
      check_eq("n2_hold", 32'(cpu_hold), 32'd0);
      check_eq("n2_err", 32'(load_err), 32'd0);
      tick();
      check_eq("n2_wr_count", 32'(wa_q.size() - base), 32'd2);
      if (wa_q.size() >= base + 2) begin
         check_eq("n2_addr0", 32'(wa_q[base]), 32'd0);
         check_eq("n2_data0", wd_q[base], 32'h20080005);
         check_eq("n2_addr1", 32'(wa_q[base+1]), 32'd1);
         check_eq("n2_data1", wd_q[base+1], 32'h8C090000);
         check_eq("n2_spacing", 32'(wc_q[base+1] - wc_q[base]), 32'd5);
      end
      check_eq("n2_ready_in_write", 32'(we_rdy_bad), 32'd0);
      check_eq("n2_xfers", 32'(xfer_cnt - x0), 32'd10);

      // Re-arm from DONE, then N=1 with an ignored start mid-word
      pulse_start();
      check_eq("rearm_hold", 32'(cpu_hold), 32'd1);
      check_eq("rearm_done", 32'(load_done), 32'd0);
      check_eq("rearm_addr", 32'(imem_addr), 32'd0);
      check_eq("rearm_ready", 32'(rx_ready), 32'd1);
      base = wa_q.size();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hDE);
      send_byte(8'hAD);
      start = 1'b1;
      send_byte(8'hBE);
      start = 1'b0;
      send_byte(8'hEF);
      rx_valid = 1'b0;
      tick();
      check_eq("rearm_wr_count", 32'(wa_q.size() - base), 32'd1);
      if (wa_q.size() >= base + 1) begin
         check_eq("rearm_addr0", 32'(wa_q[base]), 32'd0);
         check_eq("rearm_data0", wd_q[base], 32'hDEADBEEF);
      end
      check_eq("rearm_load_done", 32'(load_done), 32'd1);

      // N=0
      pulse_start();
      base = wa_q.size();
      send_byte(8'h00);
      send_byte(8'h00);
      rx_valid = 1'b0;
      check_eq("n0_done", 32'(load_done), 32'd1);
      check_eq("n0_hold", 32'(cpu_hold), 32'd0);
      tick();
      tick();
      check_eq("n0_no_write", 32'(wa_q.size() - base), 32'd0);

      // Overflow: N=257 > 256
      pulse_start();
      base = wa_q.size();
      send_byte(8'h01);
      send_byte(8'h01);
      rx_valid = 1'b0;
      check_eq("ovf_err", 32'(load_err), 32'd1);
      check_eq("ovf_hold", 32'(cpu_hold), 32'd1);
      check_eq("ovf_done", 32'(load_done), 32'd0);
      x0 = xfer_cnt;
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      repeat (3) tick();
      rx_valid = 1'b0;
      check_eq("ovf_no_consume", 32'(xfer_cnt - x0), 32'd0);
      check_eq("ovf_ready", 32'(rx_ready), 32'd0);
      check_eq("ovf_no_write", 32'(wa_q.size() - base), 32'd0);

      // Timeout mid-word
      pulse_start();
      base = wa_q.size();
      send4(8'h00, 8'h01, 8'hAA, 8'hBB);
      rx_valid = 1'b0;
      bb = cycle;
      n  = 0;
      while (!load_err && n < 40) begin
         tick();
         n++;
      end
      check_eq("to_latency", 32'(cycle - bb), 32'd16);
      check_eq("to_hold", 32'(cpu_hold), 32'd1);
      check_eq("to_no_write", 32'(wa_q.size() - base), 32'd0);

      // Reset mid-DATA, then clean N=1 load
      pulse_start();
      base = wa_q.size();
      send4(8'h00, 8'h01, 8'h11, 8'h22);
      rx_valid = 1'b0;
      reset = 1'b0;
      tick();
      check_reset_vals("mid_rst");
      reset = 1'b1;
      tick();
      send_byte(8'h00);
      send_byte(8'h01);
      send4(8'h01, 8'h02, 8'h03, 8'h04);
      rx_valid = 1'b0;
      tick();
      check_eq("post_rst_wr_count", 32'(wa_q.size() - base), 32'd1);
      if (wa_q.size() >= base + 1) begin
         check_eq("post_rst_addr", 32'(wa_q[base]), 32'd0);
         check_eq("post_rst_data", wd_q[base], 32'h01020304);
      end
      check_eq("post_rst_done", 32'(load_done), 32'd1);

      // Largest legal load: N=256
      pulse_start();
      base = wa_q.size();
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) send4(8'(i), 8'(i), 8'(i), 8'(i));
      rx_valid = 1'b0;
      tick();
      check_eq("max_wr_count", 32'(wa_q.size() - base), 32'd256);
      if (wa_q.size() >= base + 256) begin
         check_eq("max_addr_first", 32'(wa_q[base]), 32'd0);
         check_eq("max_addr_last", 32'(wa_q[base+255]), 32'hFF);
         check_eq("max_data_last", wd_q[base+255], 32'hFFFFFFFF);
      end
      check_eq("max_done", 32'(load_done), 32'd1);
      check_eq("max_err", 32'(load_err), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the single-cycle CPU reads. It receives a byte stream from a host-side byte source over a valid/ready handshake and assembles 32-bit instruction words. It writes them to consecutive word addresses and holds the CPU in reset until the load completes. It sits between the host byte link and the write port of the instruction memory. The CPU side (PC, fetch) is unchanged.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width (PC advances by 1 per word)
- TIMEOUT, 1024, maximum idle cycles between bytes once a load has begun

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low
- start  in  1  re-arm pulse; honoured only in DONE or ERR
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte; transfer = rx_valid && rx_ready
- imem_we  out  1  one-cycle write strobe to instruction memory
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word
- cpu_hold  out  1  high = CPU must be held in reset
- load_done  out  1  load completed successfully
- load_err  out  1  load aborted: length overflow or timeout

## Operation
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0, state=LEN0.
- States:
  - **LEN0:** accept length high byte, then go to LEN1.
  - **LEN1:** accept length low byte, giving N (16-bit).
    - N=0: go to DONE.
    - N>2^ADDR_W: go to ERR.
    - Otherwise: go to DATA with imem_addr=0.
  - **DATA:** accept 4 bytes, MSB first, shifting them into imem_wdata. The 4th accepted byte moves the state to WRITE.
  - **WRITE:** assert imem_we for exactly one cycle at the current imem_addr. On leaving WRITE, increment imem_addr.
    - Words written == N: go to DONE.
    - Otherwise: go to DATA.
  - **DONE:** cpu_hold=0, load_done=1.
  - **ERR:** cpu_hold=1, load_err=1.
- rx_ready=1 only in LEN0, LEN1 and DATA. It is 0 in WRITE, DONE and ERR. Bytes presented in DONE or ERR are never consumed.
- Timeout:
  - The idle counter clears on every accepted byte.
  - It runs only in LEN1 and DATA, so LEN0 waits indefinitely.
  - Counter reaching TIMEOUT-1 with no transfer: go to ERR. Bytes already assembled into a partial word are discarded and not written.
- start, honoured only in DONE or ERR:
  - Next cycle: state=LEN0, cpu_hold=1, load_done=0, load_err=0, imem_addr=0.
  - start in any other state is ignored.
- Word count is tracked as ADDR_W+1 bits so that N=2^ADDR_W is legal. imem_addr wraps to 0 only after the final write, which is harmless.

## Timing
- All outputs are registered. Nothing flows combinationally from rx_* to any output.
- rx_ready rises the first cycle after reset is released.
- imem_we is high in the cycle after the 4th byte of a word is accepted. imem_addr and imem_wdata are stable for that cycle.
- Sustained throughput: 5 cycles per word (4 byte transfers plus 1 WRITE bubble).
- cpu_hold falls and load_done rises in the cycle after the final WRITE cycle. For N=0 this is the cycle after the LEN1 transfer.
- reset low in any cycle, mid-word included, restores all reset values at the next edge. No partial write is issued.

## Structure
- Shared package contents:
  - state enum: LEN0, LEN1, DATA, WRITE, DONE, ERR
  - BYTES_PER_WORD=4
  - LEN_W=16
- Sub-module `byte_timeout`: idle counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.

## Test plan
- N=2: send 00 02 20 08 00 05 8C 09 00 00 with rx_valid always high.
  - Required: imem_we pulses at addr 0 with 0x20080005 and at addr 1 with 0x8C090000, 5 cycles apart.
  - rx_ready is low in each WRITE cycle and no byte is lost.
  - cpu_hold falls and load_done rises 1 cycle after the second write.
- N=0: send 00 00.
  - Required: no imem_we. DONE the cycle after the second byte.
- Overflow with ADDR_W=8: send 01 01.
  - Required: load_err=1, cpu_hold stays 1, no writes.
- Timeout: TIMEOUT=16, send 00 01 AA BB, then idle.
  - Required: load_err=1 exactly 16 cycles after BB is accepted, no imem_we.
- Reset mid-DATA: pull reset low after 2 data bytes.
  - Required: all outputs at reset values the next cycle.
  - A following complete load of N=1 writes addr 0 correctly.
- Re-arm: pulse start in DONE.
  - Required: cpu_hold=1, load_done=0 the next cycle.
  - A second load overwrites from addr 0.
  - A start pulse during DATA is ignored.
